// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush controller.
// State encoding plus the control and counter-event bundles.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        PscRun  = 1'b0,
        PscHalt = 1'b1
    } pscState_e;

    typedef struct packed {
        logic pcWrite;
        logic pcSrcSel;
        logic ifIdWrite;
        logic ifIdFlush;
        logic idExFlush;
        logic exMemFlush;
        logic pipeEn;
        logic halted;
    } stageCtrl_t;

    typedef struct packed {
        logic cycle;
        logic stall;
        logic flush;
        logic freeze;
    } cntEvent_t;

endpackage

// File: rtl/pipeline_stall_controller_sat.sv
// Saturating up-counter used for the performance counters.
// Holds at all-ones instead of wrapping.
module pipeline_stall_controller_sat #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] One = W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + One;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns stall, redirect, memory-wait and halt requests into
// per-stage write enables and flushes, with perf counters.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             mem_wait,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             pc_src_sel,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pipe_en,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    pscState_e  state;
    pscState_e  stateNext;
    logic       pendRedir;
    logic       pendNext;
    stageCtrl_t ctrl;
    cntEvent_t  ev;

    logic redir;
    logic isFreeze;
    logic isRedir;
    logic isStall;

    assign redir    = branch_taken | pendRedir;
    assign isFreeze = mem_wait;
    assign isRedir  = !mem_wait && redir;
    assign isStall  = !mem_wait && !redir && stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PscRun;
            pendRedir <= 1'b0;
        end else begin
            state     <= stateNext;
            pendRedir <= pendNext;
        end
    end

    // A branch seen during a freeze is remembered until the pipe moves.
    always_comb begin
        stateNext = state;
        pendNext  = pendRedir;
        if (state == PscRun) begin
            unique case (1'b1)
                isFreeze: begin
                    if (branch_taken) pendNext = 1'b1;
                end
                isRedir: pendNext = 1'b0;
                isStall: ;
                default: begin
                    if (halt_req) stateNext = PscHalt;
                end
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        ev   = '0;
        if (rst) begin
            ctrl.ifIdFlush  = 1'b1;
            ctrl.idExFlush  = 1'b1;
            ctrl.exMemFlush = 1'b1;
        end else if (state == PscHalt) begin
            ctrl.pipeEn    = 1'b1;
            ctrl.idExFlush = 1'b1;
            ctrl.halted    = 1'b1;
        end else begin
            ev.cycle = 1'b1;
            unique case (1'b1)
                isFreeze: ev.freeze = 1'b1;
                isRedir: begin
                    ctrl.pcWrite    = 1'b1;
                    ctrl.pcSrcSel   = 1'b1;
                    ctrl.ifIdWrite  = 1'b1;
                    ctrl.pipeEn     = 1'b1;
                    ctrl.ifIdFlush  = 1'b1;
                    ctrl.idExFlush  = 1'b1;
                    ctrl.exMemFlush = 1'b1;
                    ev.flush        = 1'b1;
                end
                isStall: begin
                    ctrl.pipeEn    = 1'b1;
                    ctrl.idExFlush = 1'b1;
                    ev.stall       = 1'b1;
                end
                default: begin
                    ctrl.pcWrite   = 1'b1;
                    ctrl.ifIdWrite = 1'b1;
                    ctrl.pipeEn    = 1'b1;
                end
            endcase
        end
    end

    assign pc_write     = ctrl.pcWrite;
    assign pc_src_sel   = ctrl.pcSrcSel;
    assign if_id_write  = ctrl.ifIdWrite;
    assign if_id_flush  = ctrl.ifIdFlush;
    assign id_ex_flush  = ctrl.idExFlush;
    assign ex_mem_flush = ctrl.exMemFlush;
    assign pipe_en      = ctrl.pipeEn;
    assign halted       = ctrl.halted;

    pipeline_stall_controller_sat #(.W(CNT_W)) uCycleCnt (
        .clk(clk), .rst(rst), .inc(ev.cycle), .q(cycle_cnt)
    );
    pipeline_stall_controller_sat #(.W(CNT_W)) uStallCnt (
        .clk(clk), .rst(rst), .inc(ev.stall), .q(stall_cnt)
    );
    pipeline_stall_controller_sat #(.W(CNT_W)) uFlushCnt (
        .clk(clk), .rst(rst), .inc(ev.flush), .q(flush_cnt)
    );
    pipeline_stall_controller_sat #(.W(CNT_W)) uFreezeCnt (
        .clk(clk), .rst(rst), .inc(ev.freeze), .q(freeze_cnt)
    );

endmodule
